// File: rtl/galaksija_pkg.sv
// Shared Galaksija definitions: tape buffer address width, cassette bit
// framing constants, tape player state encoding and the slot level rule.
package galaksija_pkg;

  localparam int TAPE_ADDR_W        = 14;
  localparam int TAPE_SLOTS_PER_BIT = 8;
  localparam int TAPE_BITS_PER_BYTE = 8;

  typedef enum logic [2:0] {
    TAPE_IDLE   = 3'd0,
    TAPE_LEADER = 3'd1,
    TAPE_FETCH  = 3'd2,
    TAPE_WAIT   = 3'd3,
    TAPE_LOAD   = 3'd4,
    TAPE_PLAY   = 3'd5,
    TAPE_DONE   = 3'd6
  } tape_state_t;

  // Cassette level for a slot: clock pulse low in slot 0, data pulse low in
  // the middle slot only for a 1 bit, high otherwise.
  function automatic logic tape_level(input logic [2:0] slot, input logic data_bit);
    return !((slot == 3'd0) || ((slot == 3'(TAPE_SLOTS_PER_BIT / 2)) && data_bit));
  endfunction

endpackage

// File: rtl/galaksija_tape_bitgen.sv
// Bit/slot generator: shifts one byte out LSB first as 8 slots per bit,
// paced by pace_en, and registers the resulting cassette level.
module galaksija_tape_bitgen
  import galaksija_pkg::*;
#(
  parameter int SLOT_TICKS     = 1152,
  parameter int BYTE_GAP_TICKS = 13002
) (
  input  logic       cpuclk,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       play,
  input  logic       pace_en,
  output logic       tape_bit,
  output logic       byte_end
);

  localparam int TICK_MAX = (BYTE_GAP_TICKS > SLOT_TICKS) ? BYTE_GAP_TICKS : SLOT_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [TICK_W-1:0] SLOT_LAST = TICK_W'(SLOT_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(BYTE_GAP_TICKS - 1);

  logic [7:0]        sr_q, sr_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [2:0]        slot_q, slot_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              tape_bit_q, tape_bit_d;
  logic              slot_end, bit_end, tick_wrap;
  logic [TICK_W-1:0] tick_last;

  // Next-state for the slot counters; the level is computed from the next
  // slot so tape_bit moves on the same edge as the slot it belongs to.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    sr_d       = sr_q;
    bit_idx_d  = bit_idx_q;
    slot_d     = slot_q;
    tick_d     = tick_q;
    tape_bit_d = tape_bit_q;
    slot_end   = (slot_q == 3'(TAPE_SLOTS_PER_BIT - 1));
    bit_end    = (bit_idx_q == 3'(TAPE_BITS_PER_BYTE - 1));
    tick_last  = (slot_end && bit_end) ? GAP_LAST : SLOT_LAST;
    tick_wrap  = play && pace_en && (tick_q == tick_last);
    byte_end   = tick_wrap && slot_end && bit_end;

    if (load) begin
      sr_d       = load_byte;
      bit_idx_d  = '0;
      slot_d     = '0;
      tick_d     = '0;
      tape_bit_d = tape_level(3'd0, load_byte[0]);
    end else if (play) begin
      if (tick_wrap) begin
        tick_d = '0;
        slot_d = slot_q + 3'd1;
        if (slot_end) bit_idx_d = bit_idx_q + 3'd1;
        // The line rests high between bytes while the next one is fetched.
        tape_bit_d = byte_end ? 1'b1 : tape_level(slot_d, sr_q[bit_idx_d]);
      end else if (pace_en) begin
        tick_d = tick_q + 1'b1;
      end
    end else begin
      tape_bit_d = 1'b1;
    end
  end

  // Slot state registers; the line idles high.
  always_ff @(posedge cpuclk or negedge resetn) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      // NOTE: sr is a plain register, not a memory array, so it is reset too.
      sr_q       <= '0;
      bit_idx_q  <= '0;
      slot_q     <= '0;
      tick_q     <= '0;
      tape_bit_q <= 1'b1;
    end else begin
      sr_q       <= sr_d;
      bit_idx_q  <= bit_idx_d;
      slot_q     <= slot_d;
      tick_q     <= tick_d;
      tape_bit_q <= tape_bit_d;
    end
  end

  assign tape_bit = tape_bit_q;

endmodule

// File: rtl/galaksija_tape_player.sv
// Galaksija cassette playback engine: fetches bytes from the tape buffer
// and plays them through galaksija_tape_bitgen.
// Build option: define GALAKSIJA_TAPE_LEADER_EN to precede the data with
// LEADER_BYTES bytes of 0x00.
module galaksija_tape_player
  import galaksija_pkg::*;
#(
  parameter int SLOT_TICKS     = 1152,
  parameter int BYTE_GAP_TICKS = 13002,
  parameter int LEADER_BYTES   = 32
) (
  input  logic                   cpuclk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [TAPE_ADDR_W-1:0] addr_max,
  input  logic                   pace_en,
  output logic [TAPE_ADDR_W-1:0] buf_addr,
  input  logic [7:0]             buf_q,
  output logic                   tape_bit,
  output logic                   busy,
  output logic [TAPE_ADDR_W-1:0] progress,
  output logic                   done
);

  tape_state_t            state_q, state_d;
  logic [TAPE_ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [TAPE_ADDR_W-1:0] addr_max_q, addr_max_d;
  logic [TAPE_ADDR_W-1:0] progress_q, progress_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   bg_load, bg_play, byte_end;
  logic [7:0]             bg_byte;

`ifdef GALAKSIJA_TAPE_LEADER_EN
  localparam int LEAD_W = (LEADER_BYTES > 1) ? $clog2(LEADER_BYTES) : 1;
  localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(LEADER_BYTES - 1);
  logic [LEAD_W-1:0] lead_cnt_q, lead_cnt_d;
`endif

  // Playback FSM: fetch handshake, byte sequencing and restart on start.
  always_comb begin
    state_d    = state_q;
    buf_addr_d = buf_addr_q;
    addr_max_d = addr_max_q;
    progress_d = progress_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bg_load    = 1'b0;
    bg_play    = 1'b0;
    bg_byte    = 8'h00;
`ifdef GALAKSIJA_TAPE_LEADER_EN
    lead_cnt_d = lead_cnt_q;
`endif

    case (state_q)
      TAPE_IDLE: ;
`ifdef GALAKSIJA_TAPE_LEADER_EN
      TAPE_LEADER: begin
        bg_play = 1'b1;
        if (byte_end) begin
          if (lead_cnt_q == LEAD_LAST) begin
            state_d = TAPE_FETCH;
          end else begin
            // Reloading 0x00 on the byte edge keeps leader bytes back to back.
            lead_cnt_d = lead_cnt_q + 1'b1;
            bg_load    = 1'b1;
          end
        end
      end
`endif
      TAPE_FETCH: state_d = TAPE_WAIT;
      TAPE_WAIT:  state_d = TAPE_LOAD;
      TAPE_LOAD: begin
        bg_load    = 1'b1;
        bg_byte    = buf_q;
        progress_d = buf_addr_q;
        state_d    = TAPE_PLAY;
      end
      TAPE_PLAY: begin
        bg_play = 1'b1;
        if (byte_end) begin
          if (buf_addr_q == addr_max_q) begin
            state_d = TAPE_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            buf_addr_d = buf_addr_q + 1'b1;
            state_d    = TAPE_FETCH;
          end
        end
      end
      TAPE_DONE: state_d = TAPE_IDLE;
      default:   state_d = TAPE_IDLE;
    endcase

    // A start pulse wins from any state and drops the byte in flight.
    if (start) begin
      addr_max_d = addr_max;
      buf_addr_d = '0;
      progress_d = '0;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      bg_byte    = 8'h00;
`ifdef GALAKSIJA_TAPE_LEADER_EN
      state_d    = TAPE_LEADER;
      lead_cnt_d = '0;
      bg_load    = 1'b1;
      bg_play    = 1'b0;
`else
      state_d    = TAPE_FETCH;
      bg_load    = 1'b0;
      bg_play    = 1'b0;
`endif
    end
  end

  // FSM and handshake registers.
  always_ff @(posedge cpuclk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= TAPE_IDLE;
      buf_addr_q <= '0;
      addr_max_q <= '0;
      progress_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef GALAKSIJA_TAPE_LEADER_EN
      lead_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      buf_addr_q <= buf_addr_d;
      addr_max_q <= addr_max_d;
      progress_q <= progress_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef GALAKSIJA_TAPE_LEADER_EN
      lead_cnt_q <= lead_cnt_d;
`endif
    end
  end

  galaksija_tape_bitgen #(
    .SLOT_TICKS    (SLOT_TICKS),
    .BYTE_GAP_TICKS(BYTE_GAP_TICKS)
  ) u_bitgen (
    .cpuclk   (cpuclk),
    .resetn   (resetn),
    .load     (bg_load),
    .load_byte(bg_byte),
    .play     (bg_play),
    .pace_en  (pace_en),
    .tape_bit (tape_bit),
    .byte_end (byte_end)
  );

  assign buf_addr = buf_addr_q;
  assign busy     = busy_q;
  assign progress = progress_q;
  assign done     = done_q;

endmodule

// File: doc/galaksija_tape_player.md
# galaksija_tape_player

Cassette playback engine for the Galaksija core. After an ioctl tape download completes, it reads bytes from port B of the tape buffer RAM and turns each bit into the Galaksija cassette pulse pattern. The result, `tape_bit`, is what the CPU reads at $2000. It also drives the audio tape-monitor select and the tape progress bar in `galaksija_video`. It replaces the ad-hoc read/delay counters in the top level with an explicit FSM and a RAM fetch handshake.

## Interface
- `SLOT_TICKS`, default 1152: paced cycles per bit slot (8 slots per bit).
- `BYTE_GAP_TICKS`, default 13002: paced cycles in the final slot of each byte.
- `LEADER_BYTES`, default 32: count of 0x00 leader bytes (only with the leader feature).
- `cpuclk` in 1: sole clock; all state on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse on the falling edge of `ioctl_download`; starts or restarts playback.
- `addr_max` in 14: last valid buffer address, inclusive.
- `pace_en` in 1: timing enable (real-time 3.072 MHz window); tick counters advance only when it is high.
- `buf_addr` out 14: tape buffer read address.
- `buf_q` in 8: tape buffer data; valid 1 cycle after `buf_addr`.
- `tape_bit` out 1: cassette level; idle 1.
- `busy` out 1: high from `start` until the last byte completes; drives `download_active` and audio select.
- `progress` out 14: address of the byte currently playing; drives `read_counter`.
- `done` out 1: one-cycle pulse when playback completes.

## Operation
- FSM states: IDLE, (LEADER), FETCH, WAIT, LOAD, PLAY, DONE.
- IDLE: `tape_bit`=1, `busy`=0. `start` → FETCH with `buf_addr`=0.
- FETCH: present `buf_addr`; next state WAIT.
- WAIT: one RAM latency cycle; next state LOAD.
- LOAD: latch `buf_q` into shift register `sr`; clear `bit_idx`, `slot`, `tick`; `progress`=`buf_addr`; next state PLAY.
- PLAY: bits are played LSB first. Within a bit, `slot` runs 0..7.
  - `tape_bit`=0 in slot 0 (clock pulse).
  - `tape_bit`=0 in slot 4 iff `sr[bit_idx]`=1.
  - `tape_bit`=1 otherwise.
- Slot length: `SLOT_TICKS` paced cycles, except slot 7 of bit 7, which lasts `BYTE_GAP_TICKS`.
- End of a byte:
  - if `buf_addr`==`addr_max` → DONE;
  - else `buf_addr`+1 → FETCH.
- The FETCH/WAIT/LOAD cycles do not consume paced ticks.
- DONE: pulse `done` for one cycle, deassert `busy`, go to IDLE.
- `start` in any state aborts the current byte and restarts from FETCH at address 0 (or from LEADER with the leader feature). `done` is not pulsed on abort.
- `addr_max`=0 plays exactly one byte.
- `addr_max` is sampled on `start`, so later changes to the input do not affect a running playback.

## Timing
- Reset values:
  - `tape_bit`=1, `busy`=0, `done`=0, `buf_addr`=0, `progress`=0;
  - state IDLE, counters 0.
- Latency: `start` at cycle N → `busy`=1 at N+1.
- The first slot-0 low on `tape_bit` appears at N+4 (FETCH, WAIT, LOAD each take one cycle).
- `tick` counts 0..limit-1 on `pace_en` cycles; its width is clog2(`BYTE_GAP_TICKS`).
- When `pace_en`=0, `tick` holds and `tape_bit` holds its level.
- One byte takes 63·`SLOT_TICKS` + `BYTE_GAP_TICKS` paced cycles, plus 3 unpaced fetch cycles.
- `tape_bit` is registered, so it changes exactly one cycle after the tick wrap that changes the slot.
- `busy` falls in the same cycle that `done` pulses.

## Configuration
- `GALAKSIJA_TAPE_LEADER_EN`
  - Defined: after `start`, enter LEADER and play `LEADER_BYTES` bytes of 0x00 with identical bit and slot timing. `buf_addr` stays 0 and `progress` stays 0 during the leader; then go to FETCH.
  - Undefined: no LEADER state; `start` goes directly to FETCH.

## Structure
- Shared package `galaksija_pkg`:
  - state enum `tape_state_t`;
  - `TAPE_SLOTS_PER_BIT`=8, `TAPE_BITS_PER_BYTE`=8;
  - constant `TAPE_ADDR_W`=14, used by the buffer RAM, this block and `galaksija_video`.
- One natural sub-module: `galaksija_tape_bitgen`. It owns `sr`, `bit_idx`, `slot` and `tick`, produces `tape_bit`, and raises `byte_end` to the FSM.

## Test plan
- Reset mid-PLAY (`resetn` low) → `tape_bit`=1, `busy`=0, `buf_addr`=0 immediately (asynchronous).
- `addr_max`=0, `buf_q`=0x01, `pace_en`=1 → bit 0:
  - `tape_bit` low for `SLOT_TICKS` cycles at slot 0, high for slots 1–3;
  - low at slot 4, high for slots 5–7;
  - bits 1–7 low only at slot 0;
  - `done` pulses after 63·1152+13002+3 cycles.
- Two bytes 0xAA, 0x55 with `addr_max`=1 → `progress` reads 0 then 1; the slot-4 pulse patterns alternate correctly; exactly one `done`.
- `pace_en` toggling 50% → each slot lasts 2·`SLOT_TICKS` cycles; `tape_bit` level is unchanged across held cycles.
- `start` asserted mid-byte 3 → `buf_addr` returns to 0 within 1 cycle; no `done` pulse; playback restarts from byte 0.
- With `GALAKSIJA_TAPE_LEADER_EN`, `LEADER_BYTES`=2 → 16 clock-pulse-only bits precede the first fetch; `buf_addr`=0 throughout the leader.
